mdu_ctrl: RTL



---
 rtl/mips_defs.sv | 15 +
 rtl/md_arith.sv | 29 ++
 rtl/mdu_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/mips_defs.sv
// mips_defs: shared MD opcode constants, default cycle counts and controller state type
package mips_defs;
   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   typedef enum logic {IDLE, RUN} md_state_t;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit multiply/divide result, hi:lo, with divide-by-zero flag
module md_arith
   import mips_defs::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        dz
);
   logic [63:0] sp, up;
   logic [31:0] bs, sq, sr, uq, ur;
   always_comb begin
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      up = {32'b0, a} * {32'b0, b};
      dz = (b == 32'b0);
      // a zero divisor is replaced so the dividers never see it; dz suppresses the commit
      bs = dz ? 32'd1 : b;
      sq = $signed(a) / $signed(bs);
      sr = $signed(a) % $signed(bs);
      uq = a / bs;
      ur = a % bs;
      {hi, lo} = (op == MD_MULT)  ? sp :
                 (op == MD_MULTU) ? up :
                 (op == MD_DIV)   ? {sr, sq} :
                 (op == MD_DIVU)  ? {ur, uq} : 64'b0;
   end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller owning HI/LO, busy counter and D-stage stall request
module mdu_ctrl
   import mips_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   input  logic        d_is_md,
   output logic        busy,
   output logic        start,
   output logic        stall_req,
   output logic [31:0] md_out
);
   md_state_t   state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [31:0] hi, lo, hi_n, lo_n, r_hi, r_lo;
   logic [63:0] pend, pend_n;
   logic        pdz, pdz_n, dz;

   md_arith u_arith (.op(md_op), .a(md_a), .b(md_b), .hi(r_hi), .lo(r_lo), .dz(dz));

   assign busy      = (state == RUN);
   assign start     = (md_op == MD_MULT) || (md_op == MD_MULTU) || (md_op == MD_DIV) || (md_op == MD_DIVU);
   assign stall_req = d_is_md & (start | busy);
   assign md_out    = (md_op == MD_MFHI) ? hi : (md_op == MD_MFLO) ? lo : 32'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         pend  <= '0;
         pdz   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi    <= hi_n;
         lo    <= lo_n;
         pend  <= pend_n;
         pdz   <= pdz_n;
      end
   end

   // ops arriving while busy are ignored: no restart and no mt write
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hi_n    = hi;
      lo_n    = lo;
      pend_n  = pend;
      pdz_n   = pdz;
      if (state == IDLE) begin
         if (start) begin
            state_n = RUN;
            cnt_n   = (md_op == MD_MULT || md_op == MD_MULTU) ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
            pend_n  = {r_hi, r_lo};
            pdz_n   = dz & (md_op == MD_DIV || md_op == MD_DIVU);
         end else begin
            hi_n = (md_op == MD_MTHI) ? md_a : hi;
            lo_n = (md_op == MD_MTLO) ? md_a : lo;
         end
      end else begin
         cnt_n = cnt - 16'd1;
         if (cnt == 16'd1) begin
            state_n = IDLE;
            {hi_n, lo_n} = pdz ? {hi, lo} : pend;
         end
      end
   end
endmodule
